led_pattern_sequencer: RTL

//  Autonomous sequencer that drives the 4-bit LED PIO slave via an Avalon-MM write master.

---
 rtl/led_seq_pkg.sv | 25 ++
 rtl/led_seq_csr.sv | 90 +++++++++
 rtl/led_pattern_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: CSR word addresses,
// pattern-update modes and the master-side FSM state encoding.
package led_seq_pkg;

  localparam logic [1:0] CSR_CTRL    = 2'd0;
  localparam logic [1:0] CSR_PERIOD  = 2'd1;
  localparam logic [1:0] CSR_PATTERN = 2'd2;
  localparam logic [1:0] CSR_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_SHIFT  = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    CLEAR = 3'd4
  } state_e;

endpackage

// File: rtl/led_seq_csr.sv
// CSR slave of the LED sequencer: CTRL/PERIOD/PATTERN registers, the
// zero-wait readback mux and one-cycle pulses marking CTRL/PATTERN writes.
module led_seq_csr
  import led_seq_pkg::*;
#(
  parameter int LED_W    = 4,
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          s_address,
  input  logic                s_chipselect,
  input  logic                s_write_n,
  input  logic [31:0]         s_writedata,
  output logic [31:0]         s_readdata,
  input  logic                busy,
  input  logic [7:0]          step_cnt,
  output logic                en,
  output mode_e               mode,
  output logic [PERIOD_W-1:0] period,
  output logic [LED_W-1:0]    pattern,
  output logic                ctrl_wr,
  output logic                pat_wr
);

  logic                en_r;
  mode_e               mode_r;
  logic [PERIOD_W-1:0] period_r;
  logic [LED_W-1:0]    pattern_r;
  logic                ctrl_wr_r;
  logic                pat_wr_r;
  logic                wr_s;
  logic [31:0]         rd_s;
  logic                unused_s;

  assign wr_s     = s_chipselect & ~s_write_n;
  // Upper write-data bits have no storage behind them.
  assign unused_s = ^s_writedata[31:PERIOD_W];

  // Register file update; the pulses flag the cycle the new value becomes visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_r      <= 1'b0;
      mode_r    <= MODE_STATIC;
      period_r  <= {PERIOD_W{1'b0}};
      pattern_r <= {LED_W{1'b0}};
      ctrl_wr_r <= 1'b0;
      pat_wr_r  <= 1'b0;
    end else begin
      ctrl_wr_r <= 1'b0;
      pat_wr_r  <= 1'b0;
      if (wr_s) begin
        case (s_address)
          CSR_CTRL: begin
            en_r      <= s_writedata[0];
            mode_r    <= mode_e'(s_writedata[2:1]);
            ctrl_wr_r <= 1'b1;
          end
          CSR_PERIOD:  period_r <= s_writedata[PERIOD_W-1:0];
          CSR_PATTERN: begin
            pattern_r <= s_writedata[LED_W-1:0];
            pat_wr_r  <= 1'b1;
          end
          default: ; // STATUS is read-only
        endcase
      end
    end
  end

  // Zero-wait readback mux; unused bits read as zero.
  always_comb begin
    rd_s = 32'h0000_0000;
    case (s_address)
      CSR_CTRL:    rd_s[2:0]          = {mode_r, en_r};
      CSR_PERIOD:  rd_s[PERIOD_W-1:0] = period_r;
      CSR_PATTERN: rd_s[LED_W-1:0]    = pattern_r;
      CSR_STATUS:  rd_s               = {16'h0000, step_cnt, 7'h00, busy};
      default:     rd_s               = 32'h0000_0000;
    endcase
  end

  assign s_readdata = rd_s;
  assign en         = en_r;
  assign mode       = mode_r;
  assign period     = period_r;
  assign pattern    = pattern_r;
  assign ctrl_wr    = ctrl_wr_r;
  assign pat_wr     = pat_wr_r;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Autonomous LED pattern sequencer: a CSR slave sets mode/period/seed and an
// Avalon-MM write master pushes the evolving pattern into the LED PIO.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int         LED_W    = 4,
  parameter int         PERIOD_W = 24,
  parameter logic [1:0] PIO_ADDR = 2'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
);

  logic                en_s, ctrl_wr_s, pat_wr_s, wr_evt_s, busy_s, accept_s, drive_s;
  mode_e               mode_s;
  logic [PERIOD_W-1:0] period_s, per_last_s;
  logic [LED_W-1:0]    pattern_s, upd_pat_s;

  state_e              state_r, state_nxt_s;
  logic [LED_W-1:0]    cur_pat_r, cur_pat_nxt_s;
  logic [PERIOD_W-1:0] timer_r, timer_nxt_s;
  logic                pend_r, pend_nxt_s;
  logic [7:0]          step_r;
  logic                m_cs_r, m_wn_r;
  logic [LED_W-1:0]    m_wd_r;

  led_seq_csr #(.LED_W(LED_W), .PERIOD_W(PERIOD_W)) u_csr (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_address    (s_address),
    .s_chipselect (s_chipselect),
    .s_write_n    (s_write_n),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .busy         (busy_s),
    .step_cnt     (step_r),
    .en           (en_s),
    .mode         (mode_s),
    .period       (period_s),
    .pattern      (pattern_s),
    .ctrl_wr      (ctrl_wr_s),
    .pat_wr       (pat_wr_s)
  );

  assign wr_evt_s   = ctrl_wr_s | pat_wr_s;
  assign busy_s     = (state_r != IDLE);
  assign accept_s   = ((state_r == ISSUE) || (state_r == CLEAR)) && !m_waitrequest;
  assign drive_s    = (state_nxt_s == ISSUE) || (state_nxt_s == CLEAR);
  // A period of 0 behaves as 1, so the last timer value is 0 in both cases.
  assign per_last_s = (period_s == {PERIOD_W{1'b0}}) ? {PERIOD_W{1'b0}}
                    : period_s - {{(PERIOD_W-1){1'b0}}, 1'b1};

  // Next pattern for the current mode, applied at the end of each WAIT period.
  always_comb begin
    upd_pat_s = cur_pat_r;
    case (mode_s)
      MODE_BLINK: upd_pat_s = cur_pat_r ^ pattern_s;
      MODE_SHIFT: upd_pat_s = {cur_pat_r[LED_W-2:0], cur_pat_r[LED_W-1]};
      MODE_COUNT: upd_pat_s = cur_pat_r + {{(LED_W-1){1'b0}}, 1'b1};
      default:    upd_pat_s = cur_pat_r;
    endcase
  end

  // Next-state logic; pend remembers a CTRL/PATTERN write seen while a
  // transfer was in flight so DONE can restart with the new settings.
  always_comb begin
    state_nxt_s   = state_r;
    cur_pat_nxt_s = cur_pat_r;
    timer_nxt_s   = timer_r;
    pend_nxt_s    = pend_r;
    case (state_r)
      IDLE: begin
        pend_nxt_s = 1'b0;
        if (en_s) begin
          cur_pat_nxt_s = pattern_s;
          state_nxt_s   = ISSUE;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      ISSUE: begin
        if (m_waitrequest) begin
          pend_nxt_s  = pend_r | wr_evt_s;
        end else if (!en_s) begin
          state_nxt_s = CLEAR;
          pend_nxt_s  = 1'b0;
        end else if (mode_s == MODE_STATIC) begin
          state_nxt_s = DONE;
          pend_nxt_s  = pend_r | wr_evt_s;
        end else begin
          state_nxt_s = WAIT;
          timer_nxt_s = {PERIOD_W{1'b0}};
          pend_nxt_s  = 1'b0;
        end
      end
      WAIT: begin
        if (!en_s) begin
          state_nxt_s   = CLEAR;
        end else if (timer_r == per_last_s) begin
          cur_pat_nxt_s = upd_pat_s;
          state_nxt_s   = ISSUE;
        end else begin
          timer_nxt_s   = timer_r + {{(PERIOD_W-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        if (!en_s) begin
          state_nxt_s = CLEAR;
          pend_nxt_s  = 1'b0;
        end else if (pend_r || wr_evt_s) begin
          state_nxt_s = IDLE;
          pend_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = DONE;
        end
      end
      CLEAR: begin
        if (!m_waitrequest) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM, pattern, timer and accepted-write counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      cur_pat_r <= {LED_W{1'b0}};
      timer_r   <= {PERIOD_W{1'b0}};
      pend_r    <= 1'b0;
      step_r    <= 8'd0;
    end else begin
      state_r   <= state_nxt_s;
      cur_pat_r <= cur_pat_nxt_s;
      timer_r   <= timer_nxt_s;
      pend_r    <= pend_nxt_s;
      step_r    <= accept_s ? step_r + 8'd1 : step_r;
    end
  end

  // Master outputs registered from the next state, so they stay frozen during a stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cs_r <= 1'b0;
      m_wn_r <= 1'b1;
      m_wd_r <= {LED_W{1'b0}};
    end else begin
      m_cs_r <= drive_s;
      m_wn_r <= ~drive_s;
      m_wd_r <= (state_nxt_s == ISSUE) ? cur_pat_nxt_s : {LED_W{1'b0}};
    end
  end

  assign m_address    = PIO_ADDR;
  assign m_chipselect = m_cs_r;
  assign m_write_n    = m_wn_r;
  assign m_writedata  = {{(32-LED_W){1'b0}}, m_wd_r};

endmodule
